// File: rtl/usb_in_packetizer.sv
// usb_in_packetizer: drains the byte queue and frames its contents as USB IN data packets
// (PID, payload, CRC16), streamed one byte at a time over a valid/ready handshake.
module usb_in_packetizer #(
  parameter int MAX_PKT = 64
) (
  input  logic       r_clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       zlp_req_i,
  input  logic       tog_clr_i,
  input  logic       tx_ack_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_data_i,
  output logic       fifo_r_en_o,
  output logic [7:0] tx_data_o,
  output logic       tx_valid_o,
  input  logic       tx_ready_i,
  output logic       tx_last_o,
  output logic       busy_o
);
  // state    | meaning
  // IDLE     | waiting for en with a pending ZLP or queued data
  // PID      | presenting DATA0/DATA1 PID
  // FETCH    | one-cycle queue read pulse
  // LOAD     | popped byte is on fifo_data; capture it
  // DATA     | presenting payload byte
  // CRC_LO   | presenting inverted CRC low byte
  // CRC_HI   | presenting inverted CRC high byte, tx_last high
  localparam int CW = $clog2(MAX_PKT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PKT);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_PID    = 3'd1;
  localparam logic [2:0] S_FETCH  = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_DATA   = 3'd4;
  localparam logic [2:0] S_CRC_LO = 3'd5;
  localparam logic [2:0] S_CRC_HI = 3'd6;

  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  logic [2:0]    state_q, state_d;
  logic          toggle_q, toggle_d;
  logic          zlp_q, zlp_d;
  logic          zlp_pkt_q, zlp_pkt_d;
  logic [CW-1:0] count_q, count_d, count_inc;
  logic [15:0]   crc_q, crc_d, crc_next;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_valid_q, tx_valid_d;
  logic          tx_last_q, tx_last_d;
  logic          accept;
  logic          zlp_clr;
  logic [7:0]    pid_now;

  // USB CRC16, reflected polynomial, one byte LSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] b);
    logic [15:0] c;
    c = crc_in ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign accept    = tx_valid_q & tx_ready_i;
  assign crc_next  = crc16_byte(crc_q, tx_data_q);
  assign count_inc = count_q + CW'(1);
  assign pid_now   = toggle_q ? PID_DATA1 : PID_DATA0;

  assign toggle_d = tog_clr_i ? 1'b0 : (tx_ack_i ? ~toggle_q : toggle_q);
  assign zlp_d    = zlp_req_i | (zlp_q & ~zlp_clr);

  always_comb begin
    state_d    = state_q;
    zlp_pkt_d  = zlp_pkt_q;
    count_d    = count_q;
    crc_d      = crc_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    zlp_clr    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (en_i && (zlp_q || !fifo_empty_i)) begin
          state_d    = S_PID;
          zlp_pkt_d  = zlp_q;
          tx_data_d  = pid_now;
          tx_valid_d = 1'b1;
        end
      end
      S_PID: begin
        if (accept) begin
          if (zlp_pkt_q) begin
            state_d   = S_CRC_LO;
            zlp_clr   = 1'b1;
            tx_data_d = ~crc_q[7:0];
          end else begin
            state_d    = S_FETCH;
            tx_valid_d = 1'b0;
          end
        end
      end
      S_FETCH: begin
        // single reader, so empty here only if the queue was disturbed externally
        if (fifo_empty_i) begin
          state_d    = S_CRC_LO;
          tx_data_d  = ~crc_q[7:0];
          tx_valid_d = 1'b1;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        state_d    = S_DATA;
        tx_data_d  = fifo_data_i;
        tx_valid_d = 1'b1;
      end
      S_DATA: begin
        if (accept) begin
          crc_d   = crc_next;
          count_d = count_inc;
          if ((count_inc == MAX_CNT) || fifo_empty_i) begin
            state_d   = S_CRC_LO;
            tx_data_d = ~crc_next[7:0];
          end else begin
            state_d    = S_FETCH;
            tx_valid_d = 1'b0;
          end
        end
      end
      S_CRC_LO: begin
        if (accept) begin
          state_d   = S_CRC_HI;
          tx_data_d = ~crc_q[15:8];
          tx_last_d = 1'b1;
        end
      end
      S_CRC_HI: begin
        if (accept) begin
          state_d    = S_IDLE;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
          count_d    = '0;
          crc_d      = 16'hFFFF;
        end
      end
      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge r_clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      toggle_q   <= 1'b0;
      zlp_q      <= 1'b0;
      zlp_pkt_q  <= 1'b0;
      count_q    <= '0;
      crc_q      <= 16'hFFFF;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      toggle_q   <= toggle_d;
      zlp_q      <= zlp_d;
      zlp_pkt_q  <= zlp_pkt_d;
      count_q    <= count_d;
      crc_q      <= crc_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
    end
  end

  assign fifo_r_en_o = (state_q == S_FETCH) & ~fifo_empty_i;
  assign tx_data_o   = tx_data_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_last_o   = tx_last_q;
  assign busy_o      = (state_q != S_IDLE);

endmodule

// File: tb/tb_usb_in_packetizer.sv
// Bench for usb_in_packetizer: queue model, scoreboard of expected TX bytes, and a
// negedge monitor that owns every comparison.
module tb_usb_in_packetizer;
  localparam int MAX_PKT = 64;

  logic       r_clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, zlp_req = 1'b0, tog_clr = 1'b0, tx_ack = 1'b0;
  logic       fifo_empty, fifo_r_en, tx_valid, tx_ready, tx_last, busy;
  logic [7:0] fifo_data = 8'h00;
  logic [7:0] tx_data;

  // queue model: stimulus owns f_wr, the pop process owns f_rd
  logic [7:0] fmem [0:1023];
  int         f_wr = 0, f_rd = 0;
  logic       flush_fifo = 1'b0;
  assign fifo_empty = (f_wr == f_rd);

  // scoreboard: stimulus owns e_wr, the monitor owns e_rd
  logic [8:0] exp_mem [0:2047];
  int         e_wr = 0, e_rd = 0;

  int   checks = 0, errors = 0, rd_pulses = 0;
  int   cnt_req = 0, cnt_exp = 0, cnt_base = 0;
  int   to_req = 0;
  logic rnd_ready = 1'b0;

  usb_in_packetizer #(.MAX_PKT(MAX_PKT)) dut (
    .r_clk(r_clk), .rst(rst), .en_i(en), .zlp_req_i(zlp_req), .tog_clr_i(tog_clr),
    .tx_ack_i(tx_ack), .fifo_empty_i(fifo_empty), .fifo_data_i(fifo_data),
    .fifo_r_en_o(fifo_r_en), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
    .tx_ready_i(tx_ready), .tx_last_o(tx_last), .busy_o(busy)
  );

  always #5 r_clk = ~r_clk;

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      if (r[0] ^ b[k]) r = (r >> 1) ^ 16'hA001;
      else r = r >> 1;
    end
    return r;
  endfunction

  initial begin
    logic pop;
    forever begin
      @(negedge r_clk);
      pop = fifo_r_en && rst && !fifo_empty;
      @(posedge r_clk);
      if (flush_fifo) f_rd <= f_wr;
      else if (pop) begin
        fifo_data <= fmem[f_rd];
        f_rd      <= f_rd + 1;
      end
    end
  end

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge r_clk);
      #1;
      tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor
  initial begin
    logic       stall_v, stall_l, last_acc;
    logic [7:0] stall_d;
    logic [15:0] kc;
    int         cnt_seen, to_seen;
    stall_v = 1'b0; stall_l = 1'b0; stall_d = 8'h00; last_acc = 1'b0;
    cnt_seen = 0; to_seen = 0;
    kc = 16'hFFFF;
    for (int i = 0; i < 9; i++) kc = crc_upd(kc, 8'(8'h31 + i));
    kc = ~kc;
    checks++;
    if (kc !== 16'hB4C8) begin
      errors++;
      $display("FAIL crc_model_kat got %h want b4c8", kc);
    end
    forever begin
      @(negedge r_clk);
      if (!rst) begin
        checks++;
        if (tx_valid !== 1'b0 || fifo_r_en !== 1'b0 || busy !== 1'b0 || tx_last !== 1'b0 || tx_data !== 8'h00) begin
          errors++;
          $display("FAIL reset_state got valid=%b ren=%b busy=%b last=%b data=%h want 0 0 0 0 00",
                   tx_valid, fifo_r_en, busy, tx_last, tx_data);
        end
        e_rd = e_wr;
        stall_v = 1'b0;
        last_acc = 1'b0;
      end else begin
        if (fifo_r_en) begin
          rd_pulses++;
          checks++;
          if (fifo_empty) begin
            errors++;
            $display("FAIL rd_while_empty got fifo_r_en=1 with fifo_empty=1 want no read");
          end
        end
        if (last_acc) begin
          checks++;
          if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_after_last got tx_valid=%b want 0", tx_valid);
          end
        end
        if (stall_v) begin
          checks++;
          if (tx_valid !== 1'b1 || tx_data !== stall_d || tx_last !== stall_l) begin
            errors++;
            $display("FAIL stall_hold got v=%b d=%h l=%b want v=1 d=%h l=%b",
                     tx_valid, tx_data, tx_last, stall_d, stall_l);
          end
        end
        last_acc = 1'b0;
        if (tx_valid && tx_ready) begin
          checks++;
          if (e_rd == e_wr) begin
            errors++;
            $display("FAIL unexpected_byte got %h last=%b want nothing", tx_data, tx_last);
          end else begin
            if ({tx_last, tx_data} !== exp_mem[e_rd]) begin
              errors++;
              $display("FAIL byte_%0d got data=%h last=%b want data=%h last=%b",
                       e_rd, tx_data, tx_last, exp_mem[e_rd][7:0], exp_mem[e_rd][8]);
            end
            e_rd++;
          end
          last_acc = tx_last;
        end
        stall_v = tx_valid && !tx_ready;
        stall_d = tx_data;
        stall_l = tx_last;
      end
      if (cnt_req != cnt_seen) begin
        checks++;
        if (rd_pulses - cnt_base != cnt_exp) begin
          errors++;
          $display("FAIL read_pulses got %0d want %0d", rd_pulses - cnt_base, cnt_exp);
        end
        cnt_seen = cnt_req;
      end
      if (to_req != to_seen) begin
        checks++;
        errors++;
        $display("FAIL timeout got pending=%0d busy=%b want drained", e_wr - e_rd, busy);
        to_seen = to_req;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge r_clk);
      #1;
    end
  endtask

  task automatic load_seq(input int n, input logic [7:0] seed, input int step, output int start);
    start = f_wr;
    for (int i = 0; i < n; i++) fmem[f_wr + i] = 8'(seed + i * step);
    f_wr = f_wr + n;
  endtask

  task automatic push_exp(input logic [7:0] b, input logic l);
    exp_mem[e_wr] = {l, b};
    e_wr++;
  endtask

  task automatic expect_pkt(input logic [7:0] pid, input int start, input int n);
    logic [15:0] c;
    c = 16'hFFFF;
    push_exp(pid, 1'b0);
    for (int i = 0; i < n; i++) begin
      push_exp(fmem[start + i], 1'b0);
      c = crc_upd(c, fmem[start + i]);
    end
    c = ~c;
    push_exp(c[7:0], 1'b0);
    push_exp(c[15:8], 1'b1);
  endtask

  task automatic expect_zlp(input logic [7:0] pid);
    push_exp(pid, 1'b0);
    push_exp(8'h00, 1'b0);
    push_exp(8'h00, 1'b1);
  endtask

  task automatic wait_exp(input int budget);
    int n;
    n = 0;
    while (e_rd != e_wr && n < budget) begin tick(1); n++; end
    if (e_rd != e_wr) to_req++;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((e_rd != e_wr || busy) && n < budget) begin tick(1); n++; end
    if (e_rd != e_wr || busy) to_req++;
  endtask

  task automatic wait_busy(input int budget);
    int n;
    n = 0;
    while (!busy && n < budget) begin tick(1); n++; end
    if (!busy) to_req++;
  endtask

  task automatic check_reads(input int n);
    cnt_exp = n;
    cnt_req++;
    tick(2);
  endtask

  initial begin
    int s;
    tick(3);
    rst = 1'b1;
    tick(1);

    // reset mid-packet: DATA1 packet aborted after its first payload byte
    tx_ack = 1'b1; tick(1); tx_ack = 1'b0;
    en = 1'b0;
    load_seq(4, 8'hA1, 1, s);
    push_exp(8'h4B, 1'b0);
    push_exp(fmem[s], 1'b0);
    en = 1'b1;
    wait_exp(50);
    #1 rst = 1'b0;
    flush_fifo = 1'b1;
    tick(3);
    rst = 1'b1;
    flush_fifo = 1'b0;
    tick(2);

    // 11 22 33 -> C3 11 22 33 crcL crcH
    en = 1'b0;
    load_seq(3, 8'h11, 17, s);
    expect_pkt(8'hC3, s, 3);
    cnt_base = rd_pulses;
    en = 1'b1;
    wait_drain(200);
    check_reads(3);

    // ZLP with toggle=1
    tx_ack = 1'b1; tick(1); tx_ack = 1'b0;
    expect_zlp(8'h4B);
    cnt_base = rd_pulses;
    zlp_req = 1'b1; tick(1); zlp_req = 1'b0;
    wait_drain(100);
    check_reads(0);

    // MAX_PKT+2 bytes, no ack: two DATA0 packets; tog_clr beats a simultaneous tx_ack
    tog_clr = 1'b1; tick(1); tog_clr = 1'b0;
    tog_clr = 1'b1; tx_ack = 1'b1; tick(1); tog_clr = 1'b0; tx_ack = 1'b0;
    en = 1'b0;
    load_seq(MAX_PKT + 2, 8'h05, 7, s);
    expect_pkt(8'hC3, s, MAX_PKT);
    expect_pkt(8'hC3, s + MAX_PKT, 2);
    cnt_base = rd_pulses;
    en = 1'b1;
    wait_drain(2000);
    check_reads(MAX_PKT + 2);

    // MAX_PKT+2 bytes with ack between packets; en dropped mid-packet
    en = 1'b0;
    load_seq(MAX_PKT + 2, 8'h80, 3, s);
    expect_pkt(8'hC3, s, MAX_PKT);
    en = 1'b1;
    wait_busy(20);
    en = 1'b0;
    wait_drain(2000);
    tx_ack = 1'b1; tick(1); tx_ack = 1'b0;
    expect_pkt(8'h4B, s + MAX_PKT, 2);
    en = 1'b1;
    wait_drain(200);

    // zlp_req and tx_ack during a packet: in-flight PID kept, ZLP follows with flipped PID
    en = 1'b0;
    load_seq(2, 8'hE0, 9, s);
    expect_pkt(8'h4B, s, 2);
    expect_zlp(8'hC3);
    en = 1'b1;
    wait_busy(20);
    zlp_req = 1'b1; tx_ack = 1'b1; tick(1); zlp_req = 1'b0; tx_ack = 1'b0;
    wait_drain(300);

    // random stalls: exactly MAX_PKT queued, then a ZLP
    tog_clr = 1'b1; tick(1); tog_clr = 1'b0;
    rnd_ready = 1'b1;
    en = 1'b0;
    load_seq(MAX_PKT, 8'h3C, 11, s);
    expect_pkt(8'hC3, s, MAX_PKT);
    cnt_base = rd_pulses;
    en = 1'b1;
    wait_drain(4000);
    check_reads(MAX_PKT);
    expect_zlp(8'hC3);
    zlp_req = 1'b1; tick(1); zlp_req = 1'b0;
    wait_drain(200);
    rnd_ready = 1'b0;

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
